// File: rtl/execute_mdu.sv
// Iterative RV64M-style multiply/divide unit: one shift-add or restoring-divide
// step per cycle, fixed XLEN+1 cycle latency, valid/ready handshake on both sides.
module execute_mdu #(
  parameter int XLEN    = 64,
  parameter bit WORD_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] ITER = CW'(XLEN);
  localparam bit WEN = (XLEN == 32) ? 1'b0 : WORD_EN;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic              sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic [XLEN-1:0]   a_q, a_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              wordEff, aSigned, bSigned;
  logic [XLEN-1:0]   aExt, bExt;
  logic [XLEN:0]     mulSum, divShift, divDiff;
  logic [2*XLEN-1:0] prodMag, prodSigned;
  logic [XLEN-1:0]   quo, rem, full, finalRes;

  // Operand preparation: word-mode narrowing, then sign extraction for magnitudes.
  always_comb begin
    wordEff = WEN & word;
    aSigned = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    bSigned = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    aExt = a;
    bExt = b;
    if (wordEff) begin
      aExt = aSigned ? XLEN'($signed(a[31:0])) : XLEN'(a[31:0]);
      bExt = bSigned ? XLEN'($signed(b[31:0])) : XLEN'(b[31:0]);
    end
  end

  // Per-cycle iteration datapath and completion-time sign fix-up.
  always_comb begin
    mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    divShift = {hi_q, lo_q[XLEN-1]};
    divDiff  = divShift - {1'b0, m_q};

    prodMag    = {hi_q, lo_q};
    prodSigned = (sa_q ^ sb_q) ? -prodMag : prodMag;
    quo        = (sa_q ^ sb_q) ? -lo_q : lo_q;
    rem        = sa_q ? -hi_q : hi_q;

    case (op_q)
      OP_MUL:                 full = prodSigned[XLEN-1:0];
      3'd1, 3'd2, 3'd3:       full = prodSigned[2*XLEN-1:XLEN];
      3'd4, 3'd5:             full = bz_q ? '1 : quo;
      default:                full = bz_q ? a_q : rem;
    endcase

    finalRes = full;
    if (word_q) begin
      if ((op_q != OP_MUL) && !op_q[2]) finalRes = '0;
      else                              finalRes = XLEN'($signed(full[31:0]));
    end
  end

  // Next-state and register updates; flush overrides everything else.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    word_d   = word_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bz_d     = bz_q;
    a_d      = a_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          cnt_d   = '0;
          op_d    = op;
          word_d  = wordEff;
          sa_d    = aSigned & aExt[XLEN-1];
          sb_d    = bSigned & bExt[XLEN-1];
          bz_d    = (bExt == '0);
          a_d     = aExt;
          m_d     = (bSigned & bExt[XLEN-1]) ? -bExt : bExt;
          hi_d    = '0;
          lo_d    = (aSigned & aExt[XLEN-1]) ? -aExt : aExt;
        end
      end
      BUSY: begin
        if (cnt_q == ITER) begin
          result_d = finalRes;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!op_q[2]) begin
            hi_d = mulSum[XLEN:1];
            lo_d = {mulSum[0], lo_q[XLEN-1:1]};
          end else if (!divDiff[XLEN]) begin
            hi_d = divDiff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = divShift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      a_q      <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      word_q   <= word_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bz_q     <= bz_d;
      a_q      <= a_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_execute_mdu.sv
// Directed self-checking bench for execute_mdu (XLEN=64): arithmetic corner
// cases, fixed latency, back-pressure, flush and asynchronous reset abort.
module tb_execute_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        word;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  int vectorsApplied = 0;
  int miscompares    = 0;

  execute_mdu #(.XLEN(64), .WORD_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .a(a), .b(b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectorsApplied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle; returns just after the accept edge.
  task automatic applyStimulus(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    word = w;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid, returning how many edges after accept it rose.
  task automatic waitValid(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [2:0] o, input logic w,
                       input logic [63:0] x, input logic [63:0] y, input logic [63:0] exp);
    int lat;
    applyStimulus(o, w, x, y);
    checkOutput({tag, "_busy_in_ready"}, {63'd0, in_ready}, 64'd0);
    waitValid(lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'd65);
    checkOutput({tag, "_result"}, result, exp);
    consume();
    checkOutput({tag, "_idle_after"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int lat;
    int seen;
    reset = 1'b1;
    in_valid = 1'b0;
    op = '0;
    word = 1'b0;
    a = '0;
    b = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_result", result, 64'd0);
    #22 reset = 1'b0;

    runOp("mul_neg", 3'd0, 1'b0, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp("mulhu_max", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    runOp("mulh_neg", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("mulhsu", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    runOp("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    runOp("remu_div0", 3'd7, 1'b0, 64'd17, 64'd0, 64'd17);
    runOp("divu_div0", 3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("div_div0_neg", 3'd4, 1'b0, -64'sd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("div_neg", 3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp("rem_neg", 3'd6, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("divu_big", 3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF);
    runOp("divw", 3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000);
    runOp("mulw_wrap", 3'd0, 1'b1, 64'h0000_0000_8000_0001, 64'd2, 64'h0000_0000_0000_0002);
    runOp("mulhw_illegal", 3'd1, 1'b1, 64'd123, 64'd456, 64'd0);

    // Back-pressure: result and handshake state must freeze while out_ready is low.
    applyStimulus(3'd0, 1'b0, 64'd6, 64'd7);
    waitValid(lat);
    checkOutput("bp_latency", 64'(lat), 64'd65);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_result", result, 64'd42);
      checkOutput("bp_out_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    consume();
    checkOutput("bp_released", {63'd0, in_ready}, 64'd1);

    // Flush in the middle of BUSY drops the operation for good.
    applyStimulus(3'd4, 1'b0, 64'd100, 64'd3);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("flush_out_valid", {63'd0, out_valid}, 64'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("flush_no_valid", 64'(seen), 64'd0);

    // Asynchronous reset mid-operation, then a fresh multiply.
    applyStimulus(3'd0, 1'b0, 64'd11, 64'd13);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_async_result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checkOutput("rst_no_valid", 64'(seen), 64'd0);
    runOp("mul_after_rst", 3'd0, 1'b0, 64'd2, 64'd3, 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
